debug_input_conditioner: RTL and testbench



---
 rtl/debug_input_conditioner_if.sv | 22 ++
 rtl/debug_input_conditioner.sv | 158 +++++++++++++++
 tb/tb_debug_input_conditioner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/debug_input_conditioner_if.sv
// Pushbutton/switch bus between the board pins, the conditioner and the debug consumers.
// The pins drive btn_raw. The conditioner returns clean levels and one-cycle strobes.
interface debug_input_conditioner_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_rise;
    logic [WIDTH-1:0] btn_fall;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_held;

    modport master (
        output btn_raw,
        input  btn_level, btn_rise, btn_fall, btn_press, btn_held
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_rise, btn_fall, btn_press, btn_held
    );
endinterface

// File: rtl/debug_input_conditioner.sv
// Per-bit synchroniser, debouncer, edge detector and optional auto-repeat for the raw board inputs.
// Each input bit is handled by its own debug_input_bit instance, so the bits never interact.
module debug_input_bit #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic press,
    output logic held
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    logic          accept, rise_ev, fall_ev;

    assign accept  = (s2 != level) && (db_cnt == DB_LAST);
    assign rise_ev = accept & s2;
    assign fall_ev = accept & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= rise_ev;
            fall <= fall_ev;
            if (s2 == level) begin
                db_cnt <= '0;
            end else if (accept) begin
                level  <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    if (REPEAT_EN != 0) begin : g_rep
        rep_state_t    state, state_nxt;
        logic [RW-1:0] cnt, cnt_nxt;
        logic          rep_ev;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                press <= 1'b0;
                held  <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                press <= rise_ev | rep_ev;
                held  <= (state_nxt == REPEAT);
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rep_ev    = 1'b0;
            case (state)
                IDLE: begin
                    if (rise_ev) begin
                        state_nxt = DELAY;
                        cnt_nxt   = '0;
                    end
                end
                DELAY: begin
                    if (cnt == RD_LAST) begin
                        rep_ev    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (cnt == RP_LAST) begin
                        rep_ev  = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // A release beats a repeat that is due in the same cycle.
            if (fall_ev) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                rep_ev    = 1'b0;
            end
        end
    end else begin : g_norep
        assign press = rise;
        assign held  = 1'b0;
    end
endmodule

module debug_input_conditioner #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                       clk,
    input  logic                       Rst,
    debug_input_conditioner_if.slave   bus
);
    logic [WIDTH-1:0] raw, level, rise, fall, press, held;

    assign raw           = bus.btn_raw;
    assign bus.btn_level = level;
    assign bus.btn_rise  = rise;
    assign bus.btn_fall  = fall;
    assign bus.btn_press = press;
    assign bus.btn_held  = held;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debug_input_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_bit (
            .clk   (clk),
            .rst   (Rst),
            .raw   (raw[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .press (press[i]),
            .held  (held[i])
        );
    end
endmodule

// File: tb/tb_debug_input_conditioner.sv
// Directed bench for debug_input_conditioner with short debounce and repeat timings.
module tb_debug_input_conditioner;
    localparam int W = 5;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rise_n[W];
    int   fall_n[W];

    debug_input_conditioner_if #(.WIDTH(W)) bus ();

    debug_input_conditioner #(
        .WIDTH(W), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < W; i++) begin
                rise_n[i] += int'(bus.btn_rise[i]);
                fall_n[i] += int'(bus.btn_fall[i]);
            end
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < W; i++) begin
            rise_n[i] = 0;
            fall_n[i] = 0;
        end
    endtask

    task automatic release_all();
        bus.btn_raw = '0;
        tick(8);
        chk("release_level", 32'(bus.btn_level), 32'h0);
    endtask

    initial begin
        int tot;
        bus.btn_raw = 5'h1F;
        clr_cnt();

        // 1. reset with all inputs high
        tick(3);
        chk("rst_level", 32'(bus.btn_level), 32'h0);
        chk("rst_rise",  32'(bus.btn_rise),  32'h0);
        chk("rst_fall",  32'(bus.btn_fall),  32'h0);
        chk("rst_press", 32'(bus.btn_press), 32'h0);
        chk("rst_held",  32'(bus.btn_held),  32'h0);
        Rst = 1'b0;
        tick(5);
        chk("rst_lvl_early", 32'(bus.btn_level), 32'h0);
        tick();
        chk("rst_lvl_acc",  32'(bus.btn_level), 32'h1F);
        chk("rst_rise_acc", 32'(bus.btn_rise),  32'h1F);
        chk("rst_press_acc", 32'(bus.btn_press), 32'h1F);
        tick();
        chk("rst_rise_once", 32'(bus.btn_rise), 32'h0);
        clr_cnt();
        release_all();
        tot = 0;
        for (int i = 0; i < W; i++) tot += fall_n[i];
        chk("rst_fall_cnt", 32'(tot), 32'd5);

        // 2. short glitch then a real press on bit 0
        clr_cnt();
        bus.btn_raw = 5'h01;
        tick(3);
        bus.btn_raw = 5'h00;
        tick(8);
        chk("glitch_level", 32'(bus.btn_level), 32'h0);
        chk("glitch_rise",  32'(rise_n[0]), 32'd0);
        bus.btn_raw = 5'h01;
        tick(5);
        chk("db0_early", 32'(bus.btn_level), 32'h0);
        tick();
        chk("db0_level", 32'(bus.btn_level), 32'h01);
        chk("db0_rise",  32'(bus.btn_rise),  32'h01);
        chk("db0_press", 32'(bus.btn_press), 32'h01);
        tick();
        chk("db0_strobe_off", 32'({bus.btn_rise, bus.btn_press}), 32'h0);
        release_all();

        // 3. bouncing bit 2
        clr_cnt();
        bus.btn_raw = 5'h04; tick();
        bus.btn_raw = 5'h00; tick();
        bus.btn_raw = 5'h04; tick();
        bus.btn_raw = 5'h00; tick();
        bus.btn_raw = 5'h04;
        tick(5);
        chk("bounce_early", 32'(bus.btn_level), 32'h0);
        tick();
        chk("bounce_rise", 32'(bus.btn_rise), 32'h04);
        tick(3);
        chk("bounce_rise_cnt", 32'(rise_n[2]), 32'd1);
        release_all();

        // 4/5. auto-repeat on bit 1, released so the fall lands on a repeat slot
        bus.btn_raw = 5'h02;
        tick(6);
        chk("rep_acc_press", 32'(bus.btn_press), 32'h02);
        chk("rep_acc_held",  32'(bus.btn_held),  32'h00);
        for (int t = 1; t <= 50; t++) begin
            logic ep, eh, ef, el;
            tick();
            ep = (t == 10) || (t >= 13 && t <= 43 && ((t - 10) % 3 == 0));
            eh = (t >= 10) && (t < 46);
            ef = (t == 46);
            el = (t < 46);
            chk($sformatf("rep_press_t%0d", t), 32'(bus.btn_press), 32'({3'b0, ep, 1'b0}));
            chk($sformatf("rep_held_t%0d", t),  32'(bus.btn_held),  32'({3'b0, eh, 1'b0}));
            chk($sformatf("rep_fall_t%0d", t),  32'(bus.btn_fall),  32'({3'b0, ef, 1'b0}));
            chk($sformatf("rep_level_t%0d", t), 32'(bus.btn_level), 32'({3'b0, el, 1'b0}));
            if (t == 40) bus.btn_raw = 5'h00;
        end

        // 6. simultaneous bits, then reset mid-repeat
        bus.btn_raw = 5'b10101;
        tick(6);
        chk("multi_rise",  32'(bus.btn_rise),  32'h15);
        chk("multi_level", 32'(bus.btn_level), 32'h15);
        tick();
        chk("multi_rise_off", 32'(bus.btn_rise), 32'h0);
        tick(11);
        chk("multi_held", 32'(bus.btn_held), 32'h15);
        Rst = 1'b1;
        tick();
        chk("midrst_level", 32'(bus.btn_level), 32'h0);
        chk("midrst_press", 32'(bus.btn_press), 32'h0);
        chk("midrst_held",  32'(bus.btn_held),  32'h0);
        chk("midrst_rise_fall", 32'({bus.btn_rise, bus.btn_fall}), 32'h0);
        Rst = 1'b0;
        tick(5);
        chk("post_rst_early", 32'(bus.btn_level), 32'h0);
        tick();
        chk("post_rst_rise", 32'(bus.btn_rise), 32'h15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
